// File: rtl/sda_gmem_pkg.sv
// Shared constants, state encoding and size helper for the gmem burst reader.
package sda_gmem_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam int         PAGE_BYTES     = 4096;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_DONE
  } state_t;

  function automatic logic [2:0] AXI_SIZE(input int data_width);
    return 3'($clog2(data_width / 8));
  endfunction

endpackage

// File: rtl/sda_gmem_burst_calc.sv
// Beats for the next burst: min of beats left, MAX_BURST and beats left in the 4 KB page.
module sda_gmem_burst_calc
  import sda_gmem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 16,
  parameter int LEN_WIDTH  = 16
) (
  input  logic [11:0]          page_off,
  input  logic [LEN_WIDTH-1:0] remaining,
  output logic [8:0]           burst
);

  localparam int SHIFT = int'(AXI_SIZE(DATA_WIDTH));
  localparam int CW    = (LEN_WIDTH > 13) ? LEN_WIDTH : 13;

  logic [12:0]   page_room;
  logic [CW-1:0] page_w;
  logic [CW-1:0] rem_w;
  logic [CW-1:0] cap_w;
  logic [CW-1:0] min_w;

  // page_off is beat-aligned, so the shift divides exactly
  always_comb begin
    page_room = 13'(PAGE_BYTES) - {1'b0, page_off};
    page_w    = CW'(page_room >> SHIFT);
    rem_w     = CW'(remaining);
    cap_w     = CW'(MAX_BURST);
    min_w     = (rem_w < cap_w) ? rem_w : cap_w;
    if (page_w < min_w) min_w = page_w;
    burst     = 9'(min_w);
  end

endmodule

// File: rtl/sda_gmem_burst_reader.sv
// Read-side gmem AXI4 master: splits a (address, beats) request into page-safe INCR bursts.
module sda_gmem_burst_reader
  import sda_gmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 16,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LEN_WIDTH-1:0]  req_beats,
  output logic [ADDR_WIDTH-1:0] m_axi_gmem_ARADDR,
  output logic [7:0]            m_axi_gmem_ARLEN,
  output logic [2:0]            m_axi_gmem_ARSIZE,
  output logic [1:0]            m_axi_gmem_ARBURST,
  output logic                  m_axi_gmem_ARVALID,
  input  logic                  m_axi_gmem_ARREADY,
  input  logic [DATA_WIDTH-1:0] m_axi_gmem_RDATA,
  input  logic [1:0]            m_axi_gmem_RRESP,
  input  logic                  m_axi_gmem_RLAST,
  input  logic                  m_axi_gmem_RVALID,
  output logic                  m_axi_gmem_RREADY,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic [DATA_WIDTH-1:0] dout_data,
  output logic                  dout_last,
  output logic                  done_valid,
  output logic                  done_error
);

  localparam logic [2:0]            AR_SIZE    = AXI_SIZE(DATA_WIDTH);
  localparam int                    SHIFT      = int'(AR_SIZE);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~((ADDR_WIDTH'(1) << SHIFT) - ADDR_WIDTH'(1));

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d, araddr_q;
  logic [LEN_WIDTH-1:0]  remaining_q, remaining_d, rem_after;
  logic [8:0]            burst_q, burst_nxt, beat_cnt_q, beat_cnt_d;
  logic [7:0]            arlen_q;
  logic [2:0]            arsize_q;
  logic                  err_q, err_d, load_ar, r_hs, last_beat, in_data;

  // Burst size is evaluated on the values about to be registered, so AR fields are ready on ADDR entry
  sda_gmem_burst_calc #(
    .DATA_WIDTH (DATA_WIDTH),
    .MAX_BURST  (MAX_BURST),
    .LEN_WIDTH  (LEN_WIDTH)
  ) u_burst_calc (
    .page_off  (cur_addr_d[11:0]),
    .remaining (remaining_d),
    .burst     (burst_nxt)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    cur_addr_q  <= cur_addr_d;
    remaining_q <= remaining_d;
    beat_cnt_q  <= beat_cnt_d;
    err_q       <= err_d;
    if (load_ar) burst_q <= burst_nxt;
    if (reset) begin
      araddr_q <= '0;
      arlen_q  <= '0;
      arsize_q <= '0;
    end else if (load_ar) begin
      araddr_q <= cur_addr_d;
      arlen_q  <= 8'(burst_nxt - 9'd1);
      arsize_q <= AR_SIZE;
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    beat_cnt_d  = beat_cnt_q;
    err_d       = err_q;
    load_ar     = 1'b0;
    in_data     = (state_q == ST_DATA);
    r_hs        = in_data && m_axi_gmem_RVALID && dout_ready;
    last_beat   = (beat_cnt_q == 9'd1);
    rem_after   = remaining_q - LEN_WIDTH'(burst_q);
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          cur_addr_d  = req_addr & ALIGN_MASK;
          remaining_d = req_beats;
          err_d       = 1'b0;
          if (req_beats == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ADDR;
            load_ar = 1'b1;
          end
        end
      end
      ST_ADDR: begin
        if (m_axi_gmem_ARREADY) begin
          beat_cnt_d = burst_q;
          state_d    = ST_DATA;
        end
      end
      ST_DATA: begin
        if (r_hs) begin
          beat_cnt_d = beat_cnt_q - 9'd1;
          // RLAST is only cross-checked; the local count decides where the burst ends
          if (m_axi_gmem_RRESP != AXI_RESP_OKAY || m_axi_gmem_RLAST != last_beat) err_d = 1'b1;
          if (last_beat) begin
            remaining_d = rem_after;
            cur_addr_d  = cur_addr_q + (ADDR_WIDTH'(burst_q) << SHIFT);
            if (rem_after == '0) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_ADDR;
              load_ar = 1'b1;
            end
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign req_ready          = (state_q == ST_IDLE);
  assign m_axi_gmem_ARVALID = (state_q == ST_ADDR);
  assign m_axi_gmem_ARADDR  = araddr_q;
  assign m_axi_gmem_ARLEN   = arlen_q;
  assign m_axi_gmem_ARSIZE  = arsize_q;
  assign m_axi_gmem_ARBURST = AXI_BURST_INCR;
  assign m_axi_gmem_RREADY  = in_data & dout_ready;
  assign dout_valid         = in_data & m_axi_gmem_RVALID;
  assign dout_data          = in_data ? m_axi_gmem_RDATA : '0;
  assign dout_last          = dout_valid & last_beat & (remaining_q == LEN_WIDTH'(burst_q));
  assign done_valid         = (state_q == ST_DONE);
  assign done_error         = done_valid & err_q;

endmodule

// File: tb/tb_sda_gmem_burst_reader.sv
// Directed bench for sda_gmem_burst_reader with a single-outstanding gmem read slave model.
module tb_sda_gmem_burst_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [63:0] req_addr = '0;
  logic [15:0] req_beats = '0;
  logic [63:0] m_axi_gmem_ARADDR;
  logic [7:0]  m_axi_gmem_ARLEN;
  logic [2:0]  m_axi_gmem_ARSIZE;
  logic [1:0]  m_axi_gmem_ARBURST;
  logic        m_axi_gmem_ARVALID;
  logic        m_axi_gmem_ARREADY = 1'b0;
  logic [31:0] m_axi_gmem_RDATA = '0;
  logic [1:0]  m_axi_gmem_RRESP = '0;
  logic        m_axi_gmem_RLAST = 1'b0;
  logic        m_axi_gmem_RVALID = 1'b0;
  logic        m_axi_gmem_RREADY;
  logic        dout_valid;
  logic        dout_ready = 1'b1;
  logic [31:0] dout_data;
  logic        dout_last;
  logic        done_valid;
  logic        done_error;

  sda_gmem_burst_reader #(
    .ADDR_WIDTH (64), .DATA_WIDTH (32), .MAX_BURST (16), .LEN_WIDTH (16)
  ) dut (
    .clk (clk), .reset (reset),
    .req_valid (req_valid), .req_ready (req_ready), .req_addr (req_addr), .req_beats (req_beats),
    .m_axi_gmem_ARADDR (m_axi_gmem_ARADDR), .m_axi_gmem_ARLEN (m_axi_gmem_ARLEN),
    .m_axi_gmem_ARSIZE (m_axi_gmem_ARSIZE), .m_axi_gmem_ARBURST (m_axi_gmem_ARBURST),
    .m_axi_gmem_ARVALID (m_axi_gmem_ARVALID), .m_axi_gmem_ARREADY (m_axi_gmem_ARREADY),
    .m_axi_gmem_RDATA (m_axi_gmem_RDATA), .m_axi_gmem_RRESP (m_axi_gmem_RRESP),
    .m_axi_gmem_RLAST (m_axi_gmem_RLAST), .m_axi_gmem_RVALID (m_axi_gmem_RVALID),
    .m_axi_gmem_RREADY (m_axi_gmem_RREADY),
    .dout_valid (dout_valid), .dout_ready (dout_ready), .dout_data (dout_data), .dout_last (dout_last),
    .done_valid (done_valid), .done_error (done_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // Monitor: handshakes are judged at the falling edge, i.e. on what the next rising edge samples
  logic [63:0] ar_addr_q[$];
  int          ar_len_q[$];
  int          ar_size_q[$];
  logic [31:0] beat_data[$];
  bit          beat_last[$];
  int done_cnt = 0, done_cyc = 0, acc_cyc = 0, first_ar_cyc = -1, last_cyc = 0;
  int stab_err = 0, comb_err = 0, ar_wait_seen = 0, stall_seen = 0, ar_hs_cnt = 0, r_hs_cnt = 0;
  bit done_err = 1'b0;
  bit hold = 1'b0;
  logic [63:0] hold_addr = '0;
  logic [7:0]  hold_len = '0;

  always @(negedge clk) begin
    if (!reset) begin
      if (req_valid && req_ready) begin acc_cyc = cyc; first_ar_cyc = -1; end
      if (m_axi_gmem_ARVALID) begin
        if (first_ar_cyc < 0) first_ar_cyc = cyc;
        if (hold && (m_axi_gmem_ARADDR !== hold_addr || m_axi_gmem_ARLEN !== hold_len)) stab_err++;
        hold_addr = m_axi_gmem_ARADDR;
        hold_len  = m_axi_gmem_ARLEN;
        hold      = !m_axi_gmem_ARREADY;
        if (m_axi_gmem_ARREADY) begin
          ar_addr_q.push_back(m_axi_gmem_ARADDR);
          ar_len_q.push_back(int'(m_axi_gmem_ARLEN));
          ar_size_q.push_back(int'(m_axi_gmem_ARSIZE));
          ar_hs_cnt++;
        end else ar_wait_seen++;
      end else hold = 1'b0;
      if (dout_valid && m_axi_gmem_RREADY !== dout_ready) comb_err++;
      if (dout_valid && !dout_ready) stall_seen++;
      if (m_axi_gmem_RVALID && m_axi_gmem_RREADY) begin
        if (dout_valid !== 1'b1) comb_err++;
        beat_data.push_back(dout_data);
        beat_last.push_back(dout_last);
        if (dout_last) last_cyc = cyc;
        r_hs_cnt++;
      end
      if (done_valid) begin done_cnt++; done_err = done_error; done_cyc = cyc; end
    end
  end

  // Slave model: data word = 0xD0000000 + global beat index; error/early-RLAST at absolute beat index
  int ar_seen = 0, r_seen = 0, r_left = 0, wait_cnt = 0;
  int ar_delay = 0, err_beat = -1, early_beat = -1;
  bit rand_ready = 1'b0;

  always @(posedge clk) begin
    #1;
    if (reset) begin
      r_left = 0; ar_seen = ar_hs_cnt; r_seen = r_hs_cnt; wait_cnt = 0;
    end else begin
      if (ar_seen != ar_hs_cnt) begin
        ar_seen = ar_hs_cnt;
        r_left  = ar_len_q[ar_len_q.size()-1] + 1;
      end
      if (r_seen != r_hs_cnt) begin r_seen = r_hs_cnt; r_left--; end
    end
    if (m_axi_gmem_ARVALID && !reset) begin
      m_axi_gmem_ARREADY = (wait_cnt >= ar_delay);
      wait_cnt++;
    end else begin
      m_axi_gmem_ARREADY = (ar_delay == 0);
      wait_cnt = 0;
    end
    m_axi_gmem_RVALID = (r_left > 0);
    m_axi_gmem_RDATA  = 32'hD000_0000 + 32'(r_seen);
    m_axi_gmem_RRESP  = (r_seen == err_beat) ? 2'b10 : 2'b00;
    m_axi_gmem_RLAST  = (early_beat >= 0) ? (r_seen == early_beat) : (r_left == 1);
    dout_ready        = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [63:0] addr, input int beats, output bit timed_out);
    int d0, n;
    d0 = done_cnt; n = 0;
    req_addr = addr; req_beats = 16'(beats); req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    while (done_cnt == d0 && n < 2000) begin tick(); n++; end
    timed_out = (done_cnt == d0);
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    checks++; if (m_axi_gmem_ARVALID !== 1'b0 || m_axi_gmem_RREADY !== 1'b0 || dout_valid !== 1'b0 || done_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valids got ar=%b rr=%b dv=%b done=%b want 0", m_axi_gmem_ARVALID, m_axi_gmem_RREADY, dout_valid, done_valid);
    end
    checks++; if (m_axi_gmem_ARBURST !== 2'b01 || m_axi_gmem_ARADDR !== 64'h0 || m_axi_gmem_ARLEN !== 8'h0 || m_axi_gmem_ARSIZE !== 3'h0) begin
      errors++; $display("FAIL reset_ar_fields got burst=%b addr=%h len=%0d size=%0d want 01/0/0/0", m_axi_gmem_ARBURST, m_axi_gmem_ARADDR, m_axi_gmem_ARLEN, m_axi_gmem_ARSIZE);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int a0, b0, bad; bit to;
    a0 = ar_addr_q.size(); b0 = beat_data.size();
    issue(64'h1000, 4, to);
    checks++; if (to) begin errors++; $display("FAIL single_done got timeout want done"); end
    checks++; if (ar_addr_q.size() - a0 !== 1) begin errors++; $display("FAIL single_ar_count got %0d want 1", ar_addr_q.size() - a0); end
    else begin
      checks++; if (ar_addr_q[a0] !== 64'h1000 || ar_len_q[a0] !== 3 || ar_size_q[a0] !== 2) begin
        errors++; $display("FAIL single_ar got addr=%h len=%0d size=%0d want 1000/3/2", ar_addr_q[a0], ar_len_q[a0], ar_size_q[a0]);
      end
    end
    checks++; if (beat_data.size() - b0 !== 4) begin errors++; $display("FAIL single_beats got %0d want 4", beat_data.size() - b0); end
    bad = 0;
    for (int i = 0; i < 4 && b0 + i < beat_data.size(); i++)
      if (beat_data[b0+i] !== 32'hD000_0000 + 32'(b0 + i) || beat_last[b0+i] !== (i == 3)) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL single_stream got %0d bad beats want 0", bad); end
    checks++; if (first_ar_cyc - acc_cyc !== 1) begin errors++; $display("FAIL single_ar_latency got %0d want 1", first_ar_cyc - acc_cyc); end
    checks++; if (done_cyc - last_cyc !== 1) begin errors++; $display("FAIL single_done_latency got %0d want 1", done_cyc - last_cyc); end
    checks++; if (done_err !== 1'b0) begin errors++; $display("FAIL single_done_error got %b want 0", done_err); end
  endtask

  task automatic test_split();
    int a0, b0, bad; bit to;
    logic [63:0] ea [3];
    int el [3];
    ea = '{64'h0, 64'h40, 64'h80};
    el = '{15, 15, 7};
    a0 = ar_addr_q.size(); b0 = beat_data.size();
    issue(64'h0, 40, to);
    checks++; if (to) begin errors++; $display("FAIL split_done got timeout want done"); end
    checks++; if (ar_addr_q.size() - a0 !== 3) begin errors++; $display("FAIL split_ar_count got %0d want 3", ar_addr_q.size() - a0); end
    bad = 0;
    for (int j = 0; j < 3 && a0 + j < ar_addr_q.size(); j++)
      if (ar_addr_q[a0+j] !== ea[j] || ar_len_q[a0+j] !== el[j]) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL split_ar got %0d bad ARs want 0 (0/15 40/15 80/7)", bad); end
    checks++; if (beat_data.size() - b0 !== 40) begin errors++; $display("FAIL split_beats got %0d want 40", beat_data.size() - b0); end
    bad = 0;
    for (int i = 0; i < 40 && b0 + i < beat_data.size(); i++)
      if (beat_data[b0+i] !== 32'hD000_0000 + 32'(b0 + i) || beat_last[b0+i] !== (i == 39)) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL split_stream got %0d bad beats want 0", bad); end
  endtask

  task automatic test_page_cross();
    int a0; bit to;
    a0 = ar_addr_q.size();
    issue(64'hFF8, 8, to);
    checks++; if (to) begin errors++; $display("FAIL page_done got timeout want done"); end
    checks++; if (ar_addr_q.size() - a0 !== 2) begin errors++; $display("FAIL page_ar_count got %0d want 2", ar_addr_q.size() - a0); end
    else begin
      checks++; if (ar_addr_q[a0] !== 64'hFF8 || ar_len_q[a0] !== 1 || ar_addr_q[a0+1] !== 64'h1000 || ar_len_q[a0+1] !== 5) begin
        errors++; $display("FAIL page_ar got %h/%0d %h/%0d want ff8/1 1000/5", ar_addr_q[a0], ar_len_q[a0], ar_addr_q[a0+1], ar_len_q[a0+1]);
      end
    end
  endtask

  task automatic test_align();
    int a0; bit to;
    a0 = ar_addr_q.size();
    issue(64'h1003, 1, to);
    checks++; if (to || ar_addr_q.size() - a0 !== 1) begin errors++; $display("FAIL align_ar_count got %0d timeout=%b want 1", ar_addr_q.size() - a0, to); end
    else begin
      checks++; if (ar_addr_q[a0] !== 64'h1000 || ar_len_q[a0] !== 0) begin
        errors++; $display("FAIL align_ar got %h/%0d want 1000/0", ar_addr_q[a0], ar_len_q[a0]);
      end
    end
  endtask

  task automatic test_zero_beats();
    int a0, b0; bit to;
    a0 = ar_addr_q.size(); b0 = beat_data.size();
    issue(64'h5000, 0, to);
    checks++; if (to) begin errors++; $display("FAIL zero_done got timeout want done"); end
    checks++; if (ar_addr_q.size() - a0 !== 0 || beat_data.size() - b0 !== 0) begin
      errors++; $display("FAIL zero_traffic got ars=%0d beats=%0d want 0/0", ar_addr_q.size() - a0, beat_data.size() - b0);
    end
    checks++; if (done_cyc - acc_cyc !== 1) begin errors++; $display("FAIL zero_latency got %0d want 1", done_cyc - acc_cyc); end
    checks++; if (done_err !== 1'b0) begin errors++; $display("FAIL zero_done_error got %b want 0", done_err); end
  endtask

  task automatic test_slverr();
    int b0; bit to;
    b0 = beat_data.size();
    err_beat = b0;
    issue(64'h6000, 2, to);
    err_beat = -1;
    checks++; if (to || beat_data.size() - b0 !== 2) begin errors++; $display("FAIL slverr_beats got %0d timeout=%b want 2", beat_data.size() - b0, to); end
    checks++; if (done_err !== 1'b1) begin errors++; $display("FAIL slverr_done_error got %b want 1", done_err); end
  endtask

  task automatic test_backpressure();
    int a0, b0, bad, s0, c0, w0, st0; bit to;
    a0 = ar_addr_q.size(); b0 = beat_data.size();
    s0 = stab_err; c0 = comb_err; w0 = ar_wait_seen; st0 = stall_seen;
    ar_delay = 3; rand_ready = 1'b1;
    issue(64'h2000, 20, to);
    ar_delay = 0; rand_ready = 1'b0;
    checks++; if (to) begin errors++; $display("FAIL bp_done got timeout want done"); end
    checks++; if (ar_addr_q.size() - a0 !== 2) begin errors++; $display("FAIL bp_ar_count got %0d want 2", ar_addr_q.size() - a0); end
    else begin
      checks++; if (ar_addr_q[a0] !== 64'h2000 || ar_len_q[a0] !== 15 || ar_addr_q[a0+1] !== 64'h2040 || ar_len_q[a0+1] !== 3) begin
        errors++; $display("FAIL bp_ar got %h/%0d %h/%0d want 2000/15 2040/3", ar_addr_q[a0], ar_len_q[a0], ar_addr_q[a0+1], ar_len_q[a0+1]);
      end
    end
    checks++; if (ar_wait_seen - w0 !== 6 || stab_err !== s0) begin
      errors++; $display("FAIL bp_ar_hold got waits=%0d unstable=%0d want 6/0", ar_wait_seen - w0, stab_err - s0);
    end
    checks++; if (beat_data.size() - b0 !== 20) begin errors++; $display("FAIL bp_beats got %0d want 20", beat_data.size() - b0); end
    bad = 0;
    for (int i = 0; i < 20 && b0 + i < beat_data.size(); i++)
      if (beat_data[b0+i] !== 32'hD000_0000 + 32'(b0 + i) || beat_last[b0+i] !== (i == 19)) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL bp_stream got %0d bad beats want 0", bad); end
    checks++; if (comb_err !== c0 || stall_seen == st0) begin
      errors++; $display("FAIL bp_rready got mismatches=%0d stalls=%0d want 0/>0", comb_err - c0, stall_seen - st0);
    end
    checks++; if (done_err !== 1'b0) begin errors++; $display("FAIL bp_done_error got %b want 0", done_err); end
  endtask

  task automatic test_early_rlast();
    int b0, bad; bit to;
    b0 = beat_data.size();
    early_beat = b0 + 1;
    issue(64'h4000, 4, to);
    early_beat = -1;
    checks++; if (to || beat_data.size() - b0 !== 4) begin errors++; $display("FAIL early_beats got %0d timeout=%b want 4", beat_data.size() - b0, to); end
    bad = 0;
    for (int i = 0; i < 4 && b0 + i < beat_data.size(); i++)
      if (beat_last[b0+i] !== (i == 3)) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL early_last got %0d misplaced want 0", bad); end
    checks++; if (done_err !== 1'b1) begin errors++; $display("FAIL early_done_error got %b want 1", done_err); end
  endtask

  task automatic test_reset_mid();
    int a0, b0, d0, n; bit to;
    b0 = beat_data.size(); d0 = done_cnt;
    req_addr = 64'h3000; req_beats = 16'd8; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    n = 0;
    while (beat_data.size() < b0 + 2 && n < 100) begin tick(); n++; end
    checks++; if (beat_data.size() < b0 + 2) begin errors++; $display("FAIL rst_mid_progress got %0d beats want >=2", beat_data.size() - b0); end
    reset = 1'b1;
    tick();
    checks++; if (req_ready !== 1'b1 || m_axi_gmem_ARVALID !== 1'b0 || m_axi_gmem_RREADY !== 1'b0 || dout_valid !== 1'b0 || dout_last !== 1'b0 || done_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid_ctrl got rr=%b ar=%b rd=%b dv=%b dl=%b done=%b want 1/0/0/0/0/0", req_ready, m_axi_gmem_ARVALID, m_axi_gmem_RREADY, dout_valid, dout_last, done_valid);
    end
    checks++; if (m_axi_gmem_ARADDR !== 64'h0 || m_axi_gmem_ARLEN !== 8'h0 || m_axi_gmem_ARBURST !== 2'b01 || dout_data !== 32'h0) begin
      errors++; $display("FAIL rst_mid_data got addr=%h len=%0d burst=%b data=%h want 0/0/01/0", m_axi_gmem_ARADDR, m_axi_gmem_ARLEN, m_axi_gmem_ARBURST, dout_data);
    end
    reset = 1'b0;
    repeat (3) tick();
    checks++; if (done_cnt !== d0) begin errors++; $display("FAIL rst_mid_no_done got %0d pulses want 0", done_cnt - d0); end
    a0 = ar_addr_q.size(); b0 = beat_data.size();
    issue(64'h100, 3, to);
    checks++; if (to || ar_addr_q.size() - a0 !== 1 || beat_data.size() - b0 !== 3) begin
      errors++; $display("FAIL rst_after_counts got ars=%0d beats=%0d timeout=%b want 1/3", ar_addr_q.size() - a0, beat_data.size() - b0, to);
    end else begin
      checks++; if (ar_addr_q[a0] !== 64'h100 || ar_len_q[a0] !== 2 || beat_last[b0+2] !== 1'b1 || done_err !== 1'b0) begin
        errors++; $display("FAIL rst_after_req got %h/%0d last=%b err=%b want 100/2/1/0", ar_addr_q[a0], ar_len_q[a0], beat_last[b0+2], done_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_split();
    test_page_cross();
    test_align();
    test_zero_beats();
    test_slverr();
    test_single();
    test_backpressure();
    test_early_rlast();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
